// File: rtl/alarm_ring_ctrl.sv
// alarm_ring_ctrl: alarm match/ring/snooze sequencer driving the VGA ring icon and buzzer
module alarm_ring_ctrl #(
   parameter int RING_TIMEOUT_S = 60,
   parameter int SNOOZE_S       = 300
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_half,
   input  logic       alarm_en,
   input  logic [7:0] cur_hh,
   input  logic [7:0] cur_mm,
   input  logic [7:0] cur_ss,
   input  logic [7:0] al_hh,
   input  logic [7:0] al_mm,
   input  logic       ack,
   input  logic       snooze,
   output logic       activar_alarma,
   output logic       ring_blink,
   output logic       buzzer,
   output logic [1:0] state_o
);
   localparam int MAX_S = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
   localparam int CW = $clog2(2 * MAX_S + 1);
   localparam logic [CW-1:0] RING_LAST = CW'(2 * RING_TIMEOUT_S - 1);
   localparam logic [CW-1:0] SNZ_LAST  = CW'(2 * SNOOZE_S - 1);
   localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, RINGING = 2'd2, SNOOZE = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          match_q, blink_q, blink_d, act_q, buzz_q;
   logic          match, trig, change;

   assign match  = (cur_hh == al_hh) && (cur_mm == al_mm) && (cur_ss == 8'h00);
   assign trig   = match & ~match_q;
   assign change = state_d != state_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = alarm_en ? ARMED : IDLE;
         ARMED:   state_d = !alarm_en ? IDLE : trig ? RINGING : ARMED;
         RINGING: state_d = !alarm_en ? IDLE : ack ? ARMED : snooze ? SNOOZE :
                            (tick_half && cnt_q == RING_LAST) ? ARMED : RINGING;
         SNOOZE:  state_d = !alarm_en ? IDLE : ack ? ARMED :
                            (tick_half && cnt_q == SNZ_LAST) ? RINGING : SNOOZE;
         default: state_d = IDLE;
      endcase
   end

   // a state change swallows a coincident tick: no count, no blink toggle
   always_comb begin
      cnt_d   = change ? '0 : (tick_half && state_q[1]) ? cnt_q + 1'b1 : cnt_q;
      blink_d = (state_d != RINGING) ? 1'b0 : change ? 1'b1 : tick_half ? ~blink_q : blink_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         match_q <= 1'b0;
         blink_q <= 1'b0;
         act_q   <= 1'b0;
         buzz_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         match_q <= match;
         blink_q <= blink_d;
         act_q   <= state_d == RINGING;
         buzz_q  <= blink_d;
      end
   end

   assign activar_alarma = act_q;
   assign ring_blink     = blink_q;
   assign buzzer         = buzz_q;
   assign state_o        = state_q;
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb_alarm_ring_ctrl: directed + randomized check of alarm_ring_ctrl against a countdown reference model
module tb_alarm_ring_ctrl;
   localparam int RT = 2, SN = 3;
   logic       clk = 1'b0, reset = 1'b1, tick_half = 1'b0, alarm_en = 1'b0, ack = 1'b0, snooze = 1'b0;
   logic [7:0] cur_hh = 8'h07, cur_mm = 8'h29, cur_ss = 8'h59, al_hh = 8'h07, al_mm = 8'h30;
   logic       activar_alarma, ring_blink, buzzer;
   logic [1:0] state_o;
   int vecs = 0, errs = 0, cyc = 0;
   int m_state = 0, m_left = 0;
   bit m_blink = 0, m_prev = 0;

   always #5 clk = ~clk;

   alarm_ring_ctrl #(.RING_TIMEOUT_S(RT), .SNOOZE_S(SN)) dut (
      .clk(clk), .reset(reset), .tick_half(tick_half), .alarm_en(alarm_en),
      .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_ss(cur_ss), .al_hh(al_hh), .al_mm(al_mm),
      .ack(ack), .snooze(snooze), .activar_alarma(activar_alarma), .ring_blink(ring_blink),
      .buzzer(buzzer), .state_o(state_o)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // model keeps "tick_half pulses remaining" rather than an up-counter
   task automatic model();
      bit m, trig;
      m = (cur_hh == al_hh) && (cur_mm == al_mm) && (cur_ss == 8'h00);
      trig = m && !m_prev;
      if (reset) begin
         m_state = 0; m_left = 0; m_blink = 0; m_prev = 0;
      end else begin
         m_prev = m;
         case (m_state)
            0: if (alarm_en) m_state = 1;
            1: if (!alarm_en) m_state = 0;
               else if (trig) begin m_state = 2; m_left = 2 * RT; m_blink = 1; end
            2: if (!alarm_en) m_state = 0;
               else if (ack) m_state = 1;
               else if (snooze) begin m_state = 3; m_left = 2 * SN; end
               else if (tick_half) begin
                  m_left--;
                  if (m_left == 0) m_state = 1;
                  else m_blink = !m_blink;
               end
            default: if (!alarm_en) m_state = 0;
               else if (ack) m_state = 1;
               else if (tick_half) begin
                  m_left--;
                  if (m_left == 0) begin m_state = 2; m_left = 2 * RT; m_blink = 1; end
               end
         endcase
      end
   endtask

   task automatic step();
      tick_half = (cyc % 10 == 9);
      @(posedge clk);
      model();
      #1;
      chk("state", 8'(state_o), 8'(m_state));
      chk("activar", 8'(activar_alarma), 8'(m_state == 2));
      chk("blink", 8'(ring_blink), 8'(m_state == 2 && m_blink));
      chk("buzzer", 8'(buzzer), 8'(m_state == 2 && m_blink));
      cyc++;
      ack = 1'b0; snooze = 1'b0; reset = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic to_tick();
      while (cyc % 10 != 9) step();
   endtask

   task automatic retrig();
      cur_ss = 8'h01; step();
      cur_ss = 8'h00; step();
   endtask

   initial begin
      step();
      chk("reset_state", 8'(state_o), 8'd0);
      alarm_en = 1'b1; step();
      chk("armed", 8'(state_o), 8'd1);
      cur_mm = 8'h30; cur_ss = 8'h00; step();
      chk("ring_entry", 8'(state_o), 8'd2);
      chk("ring_entry_blink", 8'(ring_blink), 8'd1);
      run(45);
      chk("timeout_armed", 8'(state_o), 8'd1);
      chk("timeout_act", 8'(activar_alarma), 8'd0);
      retrig();
      chk("rering", 8'(state_o), 8'd2);
      snooze = 1'b1; step();
      chk("snooze", 8'(state_o), 8'd3);
      run(60);
      chk("snooze_rering", 8'(state_o), 8'd2);
      ack = 1'b1; step();
      chk("ack", 8'(state_o), 8'd1);
      retrig();
      ack = 1'b1; snooze = 1'b1; step();
      chk("ack_snooze", 8'(state_o), 8'd1);
      retrig();
      alarm_en = 1'b0; ack = 1'b1; step();
      chk("en_off", 8'(state_o), 8'd0);
      alarm_en = 1'b1; step();
      retrig();
      to_tick();
      snooze = 1'b1; step();
      chk("snooze_tick", 8'(state_o), 8'd3);
      run(59);
      chk("snooze_hold", 8'(state_o), 8'd3);
      step();
      chk("snooze_end", 8'(state_o), 8'd2);
      reset = 1'b1; step();
      chk("reset_mid", 8'(state_o), 8'd0);
      chk("reset_act", 8'(activar_alarma), 8'd0);
      alarm_en = 1'b0; retrig();
      chk("idle_hold", 8'(state_o), 8'd0);
      for (int i = 0; i < 3000; i++) begin
         alarm_en = $urandom_range(0, 149) != 0;
         ack      = $urandom_range(0, 59) == 0;
         snooze   = $urandom_range(0, 39) == 0;
         reset    = $urandom_range(0, 499) == 0;
         cur_ss   = ($urandom_range(0, 29) == 0) ? 8'h00 : 8'h01;
         if ($urandom_range(0, 99) == 0) al_mm = ($urandom_range(0, 1) != 0) ? 8'h30 : 8'h31;
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
